// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults, entry layout and PC helper for the prefetching fetch stage.
package if_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_PC_STEP = 4;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] instr;
        logic [DEFAULT_XLEN-1:0] pc_plus4;
    } fq_entry_t;

    function automatic logic [DEFAULT_XLEN-1:0] next_pc(input logic [DEFAULT_XLEN-1:0] pc);
        return pc + DEFAULT_XLEN'(DEFAULT_PC_STEP);
    endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Circular prefetch buffer: DEPTH entries, synchronous flush, head shown as zero while empty.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t                   head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Prefetching fetch stage: PC generation, 1-cycle imem, prefetch queue to decode.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_queue #(
    parameter int               XLEN     = if_pkg::DEFAULT_XLEN,
    parameter int               QDEPTH   = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = if_pkg::DEFAULT_PC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    import if_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic [XLEN-1:0] issued_pc_plus4;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            has_room;
    logic            push;
    logic            pop;
    entry_t          ret_entry;
    entry_t          head;

    // Room is judged on count plus the word in flight, so a return can never find the queue full.
    assign occupancy    = {1'b0, count} + (CW+1)'(inflight);
    assign has_room     = occupancy < (CW+1)'(QDEPTH);
    assign imem_req     = !reset && !redirect_valid && has_room;
    assign imem_addr    = pc;
    assign pc_plus_step = pc + XLEN'(PC_STEP);

    assign id_valid     = (count != '0) && !redirect_valid;
    assign pop          = id_valid && id_ready;
    assign push         = inflight && !redirect_valid;
    assign ret_entry    = '{instr: imem_rdata, pc_plus4: issued_pc_plus4};
    assign id_instr     = head.instr;
    assign id_pc_plus4  = head.pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc              <= RESET_PC;
            inflight        <= 1'b0;
            issued_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc              <= pc_plus_step;
                issued_pc_plus4 <= pc_plus_step;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (ret_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (imem_req && perf_fetch_cnt != '1)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (id_valid && !id_ready && perf_stall_cnt != '1)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1)           perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, backpressure, redirects, PC wrap, mid-run reset.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req,   w_imem_req;
    logic [31:0] imem_addr,  w_imem_addr;
    logic [31:0] imem_rdata, w_imem_rdata;
    logic        id_valid,   w_id_valid;
    logic [31:0] id_instr,   w_id_instr;
    logic [31:0] id_pc_plus4, w_id_pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_stall_cnt, w_perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    if_fetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .id_ready(id_ready), .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc_plus4(w_id_pc_plus4)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_stall_cnt(w_perf_stall_cnt), .perf_flush_cnt(w_perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory models: word returned the cycle after a request is addr>>2.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= imem_addr >> 2;
        if (w_imem_req) w_imem_rdata <= w_imem_addr >> 2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = rdy;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        step();
        n_cmp++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_bad++; $display("FAIL reset_valid_req: got %b want 00", {id_valid, imem_req});
        end
        n_cmp++;
        if ({id_instr, id_pc_plus4} !== 64'h0) begin
            n_bad++; $display("FAIL reset_head: got %h want 0", {id_instr, id_pc_plus4});
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e_pc4, e_ins, e_addr;
        do_reset(1'b1);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL stream_c0: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        step();
        n_cmp++;
        if ({id_valid, imem_addr} !== {1'b0, 32'h4}) begin
            n_bad++; $display("FAIL stream_c1: got %h want %h", {id_valid, imem_addr}, {1'b0, 32'h4});
        end
        for (int k = 0; k < 6; k++) begin
            step();
            e_pc4  = 32'(4 * (k + 1));
            e_ins  = 32'(k);
            e_addr = 32'(4 * (k + 2));
            n_cmp++;
            if ({id_valid, id_pc_plus4, id_instr, imem_addr} !== {1'b1, e_pc4, e_ins, e_addr}) begin
                n_bad++;
                $display("FAIL stream_c%0d: got %h want %h", k + 2,
                         {id_valid, id_pc_plus4, id_instr, imem_addr}, {1'b1, e_pc4, e_ins, e_addr});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e_pc4, e_ins;
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) step();
        for (int c = 4; c < 10; c++) begin
            n_cmp++;
            if ({imem_req, imem_addr, id_valid, id_pc_plus4} !== {1'b0, 32'h10, 1'b1, 32'h4}) begin
                n_bad++;
                $display("FAIL full_c%0d: got %h want %h", c,
                         {imem_req, imem_addr, id_valid, id_pc_plus4}, {1'b0, 32'h10, 1'b1, 32'h4});
            end
            step();
        end
        id_ready = 1'b1;
        #1;
        n_cmp++;
        if ({id_valid, id_pc_plus4, imem_req} !== {1'b1, 32'h4, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_0: got %h want %h", {id_valid, id_pc_plus4, imem_req}, {1'b1, 32'h4, 1'b0});
        end
        for (int j = 1; j < 5; j++) begin
            step();
            e_pc4 = 32'(4 * (j + 1));
            e_ins = 32'(j);
            n_cmp++;
            if ({id_valid, id_pc_plus4, id_instr} !== {1'b1, e_pc4, e_ins}) begin
                n_bad++;
                $display("FAIL drain_%0d: got %h want %h", j,
                         {id_valid, id_pc_plus4, id_instr}, {1'b1, e_pc4, e_ins});
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        n_cmp++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_bad++; $display("FAIL redir_cycle: got %b want 00", {id_valid, imem_req});
        end
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        n_cmp++;
        if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_bad++;
            $display("FAIL redir_after: got %h want %h", {id_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
        end
        step();
        n_cmp++;
        if ({id_valid, imem_addr} !== {1'b0, 32'h104}) begin
            n_bad++; $display("FAIL redir_gap: got %h want %h", {id_valid, imem_addr}, {1'b0, 32'h104});
        end
        step();
        n_cmp++;
        if ({id_valid, id_pc_plus4, id_instr} !== {1'b1, 32'h104, 32'h40}) begin
            n_bad++;
            $display("FAIL redir_first: got %h want %h", {id_valid, id_pc_plus4, id_instr}, {1'b1, 32'h104, 32'h40});
        end
        step();
        n_cmp++;
        if ({id_valid, id_pc_plus4, id_instr} !== {1'b1, 32'h108, 32'h41}) begin
            n_bad++;
            $display("FAIL redir_second: got %h want %h", {id_valid, id_pc_plus4, id_instr}, {1'b1, 32'h108, 32'h41});
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        for (int c = 0; c < 3; c++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        n_cmp++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_first: got %b want 00", {id_valid, imem_req});
        end
        step();
        redirect_pc = 32'h300;
        #1;
        n_cmp++;
        if ({id_valid, imem_req} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_second: got %b want 00", {id_valid, imem_req});
        end
        step();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_bad++;
            $display("FAIL b2b_addr: got %h want %h", {id_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h300});
        end
        step();
        n_cmp++;
        if (id_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_gap: got %b want 0", id_valid);
        end
        step();
        n_cmp++;
        if ({id_valid, id_pc_plus4, id_instr} !== {1'b1, 32'h304, 32'hC0}) begin
            n_bad++;
            $display("FAIL b2b_first_out: got %h want %h", {id_valid, id_pc_plus4, id_instr}, {1'b1, 32'h304, 32'hC0});
        end
        step();
        n_cmp++;
        if ({id_valid, id_pc_plus4, id_instr} !== {1'b1, 32'h308, 32'hC1}) begin
            n_bad++;
            $display("FAIL b2b_second_out: got %h want %h", {id_valid, id_pc_plus4, id_instr}, {1'b1, 32'h308, 32'hC1});
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        n_cmp++;
        if (w_imem_addr !== 32'hFFFF_FFF8) begin
            n_bad++; $display("FAIL wrap_addr0: got %h want fffffff8", w_imem_addr);
        end
        step();
        n_cmp++;
        if (w_imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL wrap_addr1: got %h want fffffffc", w_imem_addr);
        end
        step();
        n_cmp++;
        if ({w_imem_addr, w_id_valid, w_id_pc_plus4, w_id_instr} !== {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFE}) begin
            n_bad++;
            $display("FAIL wrap_c2: got %h want %h", {w_imem_addr, w_id_valid, w_id_pc_plus4, w_id_instr},
                     {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFE});
        end
        step();
        n_cmp++;
        if ({w_imem_addr, w_id_valid, w_id_pc_plus4, w_id_instr} !== {32'h4, 1'b1, 32'h0, 32'h3FFF_FFFF}) begin
            n_bad++;
            $display("FAIL wrap_c3: got %h want %h", {w_imem_addr, w_id_valid, w_id_pc_plus4, w_id_instr},
                     {32'h4, 1'b1, 32'h0, 32'h3FFF_FFFF});
        end
        step();
        n_cmp++;
        if ({w_id_valid, w_id_pc_plus4, w_id_instr} !== {1'b1, 32'h4, 32'h0}) begin
            n_bad++;
            $display("FAIL wrap_c4: got %h want %h", {w_id_valid, w_id_pc_plus4, w_id_instr}, {1'b1, 32'h4, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) step();
        n_cmp++;
        if ({id_valid, imem_req, id_pc_plus4, imem_addr} !== {1'b1, 1'b0, 32'h4, 32'h10}) begin
            n_bad++;
            $display("FAIL mid_full: got %h want %h", {id_valid, imem_req, id_pc_plus4, imem_addr},
                     {1'b1, 1'b0, 32'h4, 32'h10});
        end
`ifdef IF_PERF_CNT_EN
        n_cmp++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {32'd4, 32'd4, 32'd0}) begin
            n_bad++;
            $display("FAIL perf_before: got %h want %h", {perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt},
                     {32'd4, 32'd4, 32'd0});
        end
`endif
        reset = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL mid_req_in_reset: got %b want 0", imem_req);
        end
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({id_valid, imem_addr, id_pc_plus4} !== {1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL mid_after: got %h want %h", {id_valid, imem_addr, id_pc_plus4}, {1'b0, 32'h0, 32'h0});
        end
`ifdef IF_PERF_CNT_EN
        n_cmp++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
            n_bad++;
            $display("FAIL perf_after: got %h want 0", {perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
